// File: rtl/cmp_chk_pkg.sv
// Shared definitions for the comparator result checker: FSM encoding and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmp_chk_pkg;

    localparam int DEF_WIDTH   = 6;
    localparam int DEF_NUM_VEC = 7;
    localparam int DEF_CNT_W   = 8;

    // Vector index counter width; covers the full 1..255 run length range.
    localparam int VEC_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_result_checker_expect.sv
// Purely combinational reference compare: flags whether in_res matches {0..0, a<b}.
// Latency: 0 cycles (combinational).
// Backpressure: none; evaluated every cycle regardless of handshake.
module cmp_expect #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] res,
    output logic             match
);

    logic [WIDTH-1:0] expect_val;

    // Unsigned less-than, zero-extended into the LSB; every bit must agree.
    always_comb begin
        expect_val = '0;
        expect_val = WIDTH'(a < b);
        match      = (res == expect_val);
    end

endmodule

// File: rtl/cmp_result_checker.sv
// Checks NUM_VEC comparator results per run, keeping saturating pass/fail counts and a sticky error.
// Latency: 1 cycle from sample acceptance to count/err update; done/pass land with the last update.
// Backpressure: in_ready high only while RUN; one sample per cycle. Optional CMP_CHK_FIRST_FAIL_EN adds ff_a/ff_b/ff_res.
module cmp_result_checker
    import cmp_chk_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_VEC = DEF_NUM_VEC,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_res,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
`ifdef CMP_CHK_FIRST_FAIL_EN
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic [WIDTH-1:0] ff_res,
`endif
    output logic             err
);

    localparam logic [VEC_CNT_W-1:0] LAST_IDX = VEC_CNT_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    state_t               state;
    state_t               state_nxt;
    logic [VEC_CNT_W-1:0] vec_cnt;
    logic                 sample_ok;
    logic                 accept;
    logic                 last_accept;
    logic                 run_start;

    cmp_expect #(
        .WIDTH (WIDTH)
    ) u_expect (
        .a     (in_a),
        .b     (in_b),
        .res   (in_res),
        .match (sample_ok)
    );

    assign in_ready    = (state == RUN);
    assign busy        = (state == RUN);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (vec_cnt == LAST_IDX);
    // start is only honoured outside RUN; a start during a run is dropped.
    assign run_start   = start && (state != RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start launches a run, the final acceptance closes it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = RUN;
            RUN:     if (last_accept) state_nxt = DONE;
            DONE:    if (start)       state_nxt = RUN;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Index of the next sample within the current run.
    always_ff @(posedge clk) begin
        if (!rst_n || run_start) begin
            vec_cnt <= '0;
        end else if (accept) begin
            vec_cnt <= vec_cnt + VEC_CNT_W'(1);
        end
    end

    // Saturating pass/fail counters and the sticky mismatch flag.
    always_ff @(posedge clk) begin
        if (!rst_n || run_start) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            if (sample_ok) begin
                if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
                err <= 1'b1;
            end
        end
    end

    // Run verdict, published on the same edge as the final count update.
    // The fail counter saturates but never returns to zero, so "no fails so far
    // and this one passed" equals fail_cnt == 0 after the update.
    always_ff @(posedge clk) begin
        if (!rst_n || run_start) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (last_accept) begin
            done <= 1'b1;
            pass <= (fail_cnt == '0) && sample_ok;
        end
    end

`ifdef CMP_CHK_FIRST_FAIL_EN
    // Capture operands and result of the first mismatch; err gates later ones.
    always_ff @(posedge clk) begin
        if (!rst_n || run_start) begin
            ff_a   <= '0;
            ff_b   <= '0;
            ff_res <= '0;
        end else if (accept && !sample_ok && !err) begin
            ff_a   <= in_a;
            ff_b   <= in_b;
            ff_res <= in_res;
        end
    end
`endif

endmodule

// File: tb/tb_cmp_result_checker.sv
// Self-checking bench: directed and randomized runs against a behavioural model, plus a saturation instance.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: model tracks in_ready as "a run is open".
module tb_cmp_result_checker;

    localparam int MAXC = 255;

    logic       clk;
    logic       rst_n, start, in_valid;
    logic [5:0] in_a, in_b, in_res;
    logic       in_ready, busy, done, pass, err;
    logic [7:0] pass_cnt, fail_cnt;

    logic       s_rst_n, s_start, s_valid;
    logic [5:0] s_a, s_b, s_res;
    logic       s_ready, s_busy, s_done, s_pass, s_err;
    logic [1:0] s_pass_cnt, s_fail_cnt;

`ifdef CMP_CHK_FIRST_FAIL_EN
    logic [5:0] ff_a, ff_b, ff_res;
    logic [5:0] s_ff_a, s_ff_b, s_ff_res;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model of one checker (default parameters)
    bit   m_run;
    int   m_acc, m_pass_c, m_fail_c;
    bit   m_err, m_done, m_pass;
    int   m_ff_a, m_ff_b, m_ff_res;

    logic [5:0] va [7] = '{6'b101010, 6'b000011, 6'b001100, 6'b111111, 6'b010101, 6'b000000, 6'b001111};
    logic [5:0] vb [7] = '{6'b010101, 6'b000111, 6'b110011, 6'b000000, 6'b010101, 6'b111111, 6'b011110};
    logic [5:0] vr [7] = '{6'b000000, 6'b000001, 6'b000001, 6'b000000, 6'b000000, 6'b000001, 6'b000001};

    cmp_result_checker #(.WIDTH(6), .NUM_VEC(7), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_res(in_res), .busy(busy), .done(done), .pass(pass),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
`ifdef CMP_CHK_FIRST_FAIL_EN
        .ff_a(ff_a), .ff_b(ff_b), .ff_res(ff_res),
`endif
        .err(err)
    );

    cmp_result_checker #(.WIDTH(6), .NUM_VEC(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(s_rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
        .in_a(s_a), .in_b(s_b), .in_res(s_res), .busy(s_busy), .done(s_done), .pass(s_pass),
        .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt),
`ifdef CMP_CHK_FIRST_FAIL_EN
        .ff_a(s_ff_a), .ff_b(s_ff_b), .ff_res(s_ff_res),
`endif
        .err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Spec-level model: a run is an open window of NUM_VEC accepted samples.
    task automatic model_step();
        if (!rst_n) begin
            m_run = 0; m_acc = 0; m_pass_c = 0; m_fail_c = 0;
            m_err = 0; m_done = 0; m_pass = 0;
            m_ff_a = 0; m_ff_b = 0; m_ff_res = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_acc = 0; m_pass_c = 0; m_fail_c = 0;
                m_err = 0; m_done = 0; m_pass = 0;
                m_ff_a = 0; m_ff_b = 0; m_ff_res = 0;
            end
        end else if (in_valid) begin
            m_acc++;
            if (int'(in_res) == ((in_a < in_b) ? 1 : 0)) begin
                m_pass_c = (m_pass_c + 1 > MAXC) ? MAXC : m_pass_c + 1;
            end else begin
                m_fail_c = (m_fail_c + 1 > MAXC) ? MAXC : m_fail_c + 1;
                if (!m_err) begin
                    m_ff_a = int'(in_a); m_ff_b = int'(in_b); m_ff_res = int'(in_res);
                end
                m_err = 1;
            end
            if (m_acc == 7) begin
                m_run = 0; m_done = 1; m_pass = (m_fail_c == 0);
            end
        end
    endtask

    task automatic cyc(input logic rn, input logic st, input logic v,
                       input logic [5:0] a, input logic [5:0] b, input logic [5:0] r);
        rst_n = rn; start = st; in_valid = v; in_a = a; in_b = b; in_res = r;
        model_step();
        @(posedge clk); #1;
        chk("in_ready", int'(in_ready), int'(m_run));
        chk("busy", int'(busy), int'(m_run));
        chk("done", int'(done), int'(m_done));
        chk("pass", int'(pass), int'(m_pass));
        chk("pass_cnt", int'(pass_cnt), m_pass_c);
        chk("fail_cnt", int'(fail_cnt), m_fail_c);
        chk("err", int'(err), int'(m_err));
`ifdef CMP_CHK_FIRST_FAIL_EN
        chk("ff_a", int'(ff_a), m_ff_a);
        chk("ff_b", int'(ff_b), m_ff_b);
        chk("ff_res", int'(ff_res), m_ff_res);
`endif
    endtask

    task automatic idle_cyc(input logic v);
        cyc(1'b1, 1'b0, v, 6'($urandom), 6'($urandom), 6'($urandom));
    endtask

    task automatic s_cyc(input logic rn, input logic st, input logic v);
        s_rst_n = rn; s_start = st; s_valid = v;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [5:0] a, b, r;
        s_rst_n = 0; s_start = 0; s_valid = 0;
        s_a = 6'd5; s_b = 6'd2; s_res = 6'd1;   // a<b false, so res=1 always mismatches

        // reset state
        cyc(1'b0, 1'b0, 1'b0, '0, '0, '0);
        cyc(1'b0, 1'b1, 1'b1, '0, '0, '0);
        chk("rst_ready", int'(in_ready), 0);

        // valid high in IDLE must be ignored, including on the start cycle
        idle_cyc(1'b1); idle_cyc(1'b1);
        cyc(1'b1, 1'b1, 1'b1, va[0], vb[0], 6'd0);

        // clean run, back to back
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b1, va[i], vb[i], vr[i]);
        chk("clean_pass_cnt", int'(pass_cnt), 7);
        chk("clean_fail_cnt", int'(fail_cnt), 0);
        chk("clean_done_pass", int'({done, pass, err}), 3'b110);
        chk("clean_ready_drop", int'(in_ready), 0);
        idle_cyc(1'b1); idle_cyc(1'b0);

        // restart from DONE, vector 3 wrong
        cyc(1'b1, 1'b1, 1'b0, '0, '0, '0);
        chk("restart_clear", int'({done, pass, err}), 0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b1, va[i], vb[i], (i == 2) ? 6'd0 : vr[i]);
        chk("one_fail_fail_cnt", int'(fail_cnt), 1);
        chk("one_fail_pass_cnt", int'(pass_cnt), 6);
        chk("one_fail_flags", int'({done, pass, err}), 3'b101);
`ifdef CMP_CHK_FIRST_FAIL_EN
        chk("ff_capture", int'({ff_a, ff_b, ff_res}), int'({6'b001100, 6'b110011, 6'b000000}));
`endif

        // alternate valid, start pulses during RUN ignored
        cyc(1'b1, 1'b1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b1, 1'b0, va[i], vb[i], 6'd3);
            cyc(1'b1, (i == 3), 1'b1, va[i], vb[i], vr[i]);
        end
        chk("alt_pass_cnt", int'(pass_cnt), 7);
        chk("alt_ready_drop", int'(in_ready), 0);

        // reset after three accepted samples, then a fresh good run
        cyc(1'b1, 1'b1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, va[i], vb[i], vr[i]);
        cyc(1'b0, 1'b0, 1'b1, va[3], vb[3], vr[3]);
        chk("midrst_cnts", int'({pass_cnt, fail_cnt}), 0);
        idle_cyc(1'b1);
        chk("midrst_no_done", int'({done, busy}), 0);
        cyc(1'b1, 1'b1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b1, va[i], vb[i], vr[i]);
        chk("midrst_rerun_pass", int'(pass), 1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            a = 6'($urandom); b = 6'($urandom);
            r = ($urandom_range(0, 5) != 0) ? ((a < b) ? 6'd1 : 6'd0) : 6'($urandom);
            cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) != 0), a, b, r);
        end

        // saturation instance: CNT_W=2, NUM_VEC=5, every sample fails
        s_cyc(1'b0, 1'b0, 1'b0);
        s_cyc(1'b1, 1'b1, 1'b0);
        chk("sat_ready", int'(s_ready), 1);
        for (int k = 1; k <= 5; k++) begin
            s_cyc(1'b1, 1'b0, 1'b1);
            chk("sat_fail_cnt", int'(s_fail_cnt), (k > 3) ? 3 : k);
        end
        chk("sat_done", int'(s_done), 1);
        chk("sat_pass", int'(s_pass), 0);
        chk("sat_err", int'(s_err), 1);
        chk("sat_pass_cnt", int'(s_pass_cnt), 0);
        chk("sat_ready_drop", int'(s_ready), 0);
        s_cyc(1'b1, 1'b0, 1'b1);
        chk("sat_hold", int'(s_fail_cnt), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmp_result_checker.md
CMP_RESULT_CHECKER -- requirements
Module: cmp_result_checker

Interface
REQ-001 Parameter WIDTH, default 6: operand and result width in bits.
REQ-002 Parameter NUM_VEC, default 7: number of vectors checked per run; legal range 1..255.
REQ-003 Parameter CNT_W, default 8: width of the pass and fail counters.
REQ-004 The block SHALL have one clock, `clk`, and a synchronous, active-low reset, `rst_n`.
REQ-005 Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a run.
- in_valid  input  1  sample presented.
- in_ready  output  1  checker accepting samples.
- in_a  input  WIDTH  operand A applied to the comparator.
- in_b  input  WIDTH  operand B applied to the comparator.
- in_res  input  WIDTH  comparator output under check.
- busy  output  1  run in progress.
- done  output  1  run complete.
- pass  output  1  run completed with zero failures.
- pass_cnt  output  CNT_W  matching samples.
- fail_cnt  output  CNT_W  mismatching samples.
- err  output  1  sticky; set by the first mismatch of a run.

Function
REQ-006 Expected value SHALL be {WIDTH-1 zeros, (in_a < in_b)}, using an unsigned compare; a sample passes only when in_res equals this value in all WIDTH bits.
REQ-007 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE → RUN on start.
- RUN → DONE on acceptance of sample NUM_VEC.
- DONE → RUN on start.
REQ-008 Entering RUN from IDLE or DONE SHALL clear pass_cnt, fail_cnt, err, done and pass in the same edge.
REQ-009 in_ready SHALL be 1 only in RUN; a sample is accepted on a clock edge where in_valid and in_ready are both 1.
REQ-010 in_valid SHALL be ignored in IDLE and DONE.
REQ-011 The result of an accepted sample SHALL appear in pass_cnt or fail_cnt (and in err) on the next edge: latency 1 cycle.
REQ-012 After NUM_VEC acceptances, in_ready SHALL drop in the cycle following the final acceptance.
REQ-013 done and pass SHALL become valid together with the last count update.
REQ-014 Once valid, pass SHALL equal (fail_cnt == 0) and SHALL be held until the next start or reset.
REQ-015 busy SHALL be 1 exactly while the state is RUN.
REQ-016 start asserted during RUN SHALL be ignored; the run continues unaffected.
REQ-017 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 in_valid held high continuously SHALL allow one acceptance per cycle with no bubbles.

Reset
REQ-019 When rst_n is 0 at a clock edge, the block SHALL enter IDLE, and the following outputs SHALL be 0:
- in_ready, busy, done, pass, err
- pass_cnt, fail_cnt
REQ-020 Reset asserted mid-run SHALL discard the partial run; no done pulse and no count update SHALL follow it.

Configuration
REQ-021 Macro CMP_CHK_FIRST_FAIL_EN: when defined, the block SHALL add outputs ff_a, ff_b and ff_res (each WIDTH bits).
- They capture in_a, in_b and in_res of the first mismatching sample of a run.
- They are held until the next run start or reset, and are cleared to 0 at both.
REQ-022 When CMP_CHK_FIRST_FAIL_EN is undefined, these ports and their registers SHALL be absent, with no other behavioural change.

Structure
REQ-023 A shared package cmp_chk_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH, NUM_VEC and CNT_W constants.
REQ-024 The expected-value compare SHALL be a sub-module, cmp_expect, that is purely combinational and instantiated once.

Verification
REQ-025 Clean run: reset, start, then seven back-to-back samples with correct in_res values (a=101010, b=010101, res=000000 ... a=001111, b=011110, res=000001) → pass_cnt=7, fail_cnt=0, done=1, pass=1, err=0.
REQ-026 Single failure: same vectors but vector 3 (a=001100, b=110011) given res=000000 → fail_cnt=1, pass_cnt=6, err=1, pass=0; with the macro defined, ff_a=001100, ff_b=110011, ff_res=000000.
REQ-027 Handshake: samples presented with in_valid low on alternate cycles and in_valid high in IDLE before start → only samples taken while in RUN are counted; in_ready=0 in the cycle after the 7th acceptance.
REQ-028 Reset mid-run: reset after 3 accepted samples → all outputs 0 and state IDLE; a new start followed by 7 good samples → pass=1.
REQ-029 Restart and ignore: start pulsed during RUN → counts unaffected; start in DONE → counters and err clear on the same edge and a new run begins.
REQ-030 Saturation: CNT_W=2, NUM_VEC=5, all samples failing → fail_cnt=3 (saturated), done=1, pass=0.
